// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one iterative sin/cos CORDIC engine among NREQ requesters.
// Define CORDIC_SCHED_PRIO0_EN to give requester 0 fixed top priority over the round-robin group.
module cordic_sched #(
    parameter int  NREQ = 4,
    parameter int  W    = 16,
    parameter int  ITER = 16,
    parameter int  IW   = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_theta,
    output logic [NREQ-1:0]   req_ready,
    output logic              eng_load,
    output logic [W-1:0]      eng_theta,
    output logic              eng_step,
    output logic [IW-1:0]     eng_iter,
    input  logic [W-1:0]      eng_x,
    input  logic [W-1:0]      eng_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sin,
    output logic [W-1:0]      rsp_cos,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_RESP} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr, id_q, grant_idx, next_ptr;
    logic           grant_found;
    logic [IW-1:0]  iter_cnt;
    logic [W-1:0]   theta_q, sin_q, cos_q;
    logic           cap_q;
    logic           transfer;
    logic           last_step;

    // Scan rr_ptr, rr_ptr+1, ... modulo NREQ; the first valid requester wins.
    always_comb begin
        logic [IDW:0] scan;
        // NOTE: every variable written here gets a default first so no path infers a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (scan >= (IDW+1)'(NREQ))
                scan = scan - (IDW+1)'(NREQ);
            if (!grant_found && req_valid[scan[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan[IDW-1:0];
            end
        end
`ifdef CORDIC_SCHED_PRIO0_EN
        if (req_valid[0]) begin
            grant_found = 1'b1;
            grant_idx   = '0;
        end
`endif
    end

    assign req_ready = (state == S_IDLE && !rst && grant_found) ? (NREQ'(1) << grant_idx) : '0;
    assign transfer  = |req_ready;
    assign last_step = (iter_cnt == IW'(ITER - 1));
    assign next_ptr  = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        eng_load  = 1'b0;
        eng_theta = '0;
        eng_step  = 1'b0;
        eng_iter  = '0;
        rsp_valid = 1'b0;
        rsp_id    = '0;
        rsp_sin   = '0;
        rsp_cos   = '0;
        case (state)
            S_IDLE: if (transfer) state_nxt = S_LOAD;
            S_LOAD: begin
                eng_load  = 1'b1;
                eng_theta = theta_q;
                state_nxt = S_ITER;
            end
            S_ITER: begin
                eng_step = 1'b1;
                eng_iter = iter_cnt;
                if (last_step) state_nxt = S_RESP;
            end
            S_RESP: begin
                // The last step lands on the edge that enters RESP, so the first
                // RESP cycle shows the engine directly and later cycles the held copy.
                rsp_valid = 1'b1;
                rsp_id    = id_q;
                rsp_sin   = cap_q ? eng_y : sin_q;
                rsp_cos   = cap_q ? eng_x : cos_q;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            iter_cnt <= '0;
            theta_q  <= '0;
            id_q     <= '0;
            cap_q    <= 1'b0;
            sin_q    <= '0;
            cos_q    <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (transfer) begin
                        theta_q <= req_theta[int'(grant_idx)*W +: W];
                        id_q    <= grant_idx;
                    end
                end
                S_LOAD: iter_cnt <= '0;
                S_ITER: begin
                    iter_cnt <= iter_cnt + 1'b1;
                    if (last_step) cap_q <= 1'b1;
                end
                S_RESP: begin
                    if (cap_q) begin
                        sin_q <= eng_y;
                        cos_q <= eng_x;
                        cap_q <= 1'b0;
                    end
                    if (rsp_ready) begin
`ifdef CORDIC_SCHED_PRIO0_EN
                        if (id_q != '0) rr_ptr <= next_ptr;
`else
                        rr_ptr <= next_ptr;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: random jobs against a grant/latency reference model, plus a small
// NREQ=2 / ITER=8 instance. Engine stub: load y:=theta, x:=0; each step x:=x+1.
module tb_cordic_sched;

    localparam int NREQ = 4, W = 16, ITER = 16, IW = 4, IDW = 2;
    localparam int N2 = 2, ITER2 = 8, IW2 = 3, IDW2 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req_valid = '0;
    logic [W-1:0]      theta_arr [NREQ];
    logic [NREQ*W-1:0] req_theta;
    logic [NREQ-1:0]   req_ready;
    logic              eng_load, eng_step, rsp_valid, busy;
    logic              rsp_ready = 1'b1;
    logic [W-1:0]      eng_theta, eng_x, eng_y, rsp_sin, rsp_cos;
    logic [IW-1:0]     eng_iter;
    logic [IDW-1:0]    rsp_id;

    logic [N2-1:0]     req_valid_b = '0;
    logic [N2*W-1:0]   req_theta_b = '0;
    logic [N2-1:0]     req_ready_b;
    logic              eng_load_b, eng_step_b, rsp_valid_b, busy_b;
    logic              rsp_ready_b = 1'b1;
    logic [W-1:0]      eng_theta_b, eng_x_b, eng_y_b, rsp_sin_b, rsp_cos_b;
    logic [IW2-1:0]    eng_iter_b;
    logic [IDW2-1:0]   rsp_id_b;

    for (genvar k = 0; k < NREQ; k++) begin : g_theta
        assign req_theta[k*W +: W] = theta_arr[k];
    end

    cordic_sched #(.NREQ(NREQ), .W(W), .ITER(ITER), .IW(IW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_theta(req_theta), .req_ready(req_ready),
        .eng_load(eng_load), .eng_theta(eng_theta), .eng_step(eng_step), .eng_iter(eng_iter),
        .eng_x(eng_x), .eng_y(eng_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sin(rsp_sin), .rsp_cos(rsp_cos), .busy(busy)
    );

    cordic_sched #(.NREQ(N2), .W(W), .ITER(ITER2), .IW(IW2)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_theta(req_theta_b), .req_ready(req_ready_b),
        .eng_load(eng_load_b), .eng_theta(eng_theta_b), .eng_step(eng_step_b), .eng_iter(eng_iter_b),
        .eng_x(eng_x_b), .eng_y(eng_y_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
        .rsp_id(rsp_id_b), .rsp_sin(rsp_sin_b), .rsp_cos(rsp_cos_b), .busy(busy_b)
    );

    // Engine stubs
    always @(posedge clk) begin
        if (eng_load) begin eng_y <= eng_theta; eng_x <= '0; end
        else if (eng_step) eng_x <= eng_x + 1'b1;
        if (eng_load_b) begin eng_y_b <= eng_theta_b; eng_x_b <= '0; end
        else if (eng_step_b) eng_x_b <= eng_x_b + 1'b1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    int m_rr = 0;
    int last_accept = 0;

    // Reference: grant is the first valid requester at or after the pointer, cyclically.
    function automatic int model_grant(input logic [NREQ-1:0] v, input int rr);
        int j;
`ifdef CORDIC_SCHED_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int i = 0; i < NREQ; i++) begin
            j = (rr + i) % NREQ;
            if (v[j[IDW-1:0]]) return j;
        end
        return -1;
    endfunction

    function automatic int model_next_rr(input int id, input int rr);
`ifdef CORDIC_SCHED_PRIO0_EN
        if (id == 0) return rr;
`endif
        return (id + 1) % NREQ;
    endfunction

    // Runs one full job on dut from an IDLE negedge; returns at the next IDLE negedge.
    task automatic do_job(input int hold, input logic [NREQ-1:0] pulse, input bit drop,
                          input int exp_gap, output int got_id);
        int exp_id;
        logic [NREQ-1:0] exp_rdy;
        logic [W-1:0] exp_theta;
        #1;
        exp_id = model_grant(req_valid, m_rr);
        got_id = -1;
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) got_id = k;
        n_cmp++;
        if (exp_id < 0) begin
            n_bad++;
            $display("FAIL job_setup: no valid request (req_valid=%b)", req_valid);
            return;
        end
        exp_rdy = NREQ'(1) << exp_id;
        exp_theta = theta_arr[exp_id];
        if (req_ready !== exp_rdy) begin
            n_bad++;
            $display("FAIL grant: req_ready=%b expected %b (valid=%b rr=%0d)", req_ready, exp_rdy, req_valid, m_rr);
        end
        if (exp_gap > 0) begin
            n_cmp++;
            if (cyc - last_accept !== exp_gap) begin
                n_bad++;
                $display("FAIL accept_gap: got %0d cycles expected %0d", cyc - last_accept, exp_gap);
            end
        end
        last_accept = cyc;
        rsp_ready = (hold == 0);
        for (int c = 1; c <= ITER + 1; c++) begin
            @(negedge clk);
            if (drop && c == 1) req_valid[exp_id] = 1'b0;
            if (c == 2) theta_arr[exp_id] = W'($urandom);
            if (c == 5) req_valid = req_valid | pulse;
            if (c == 10) req_valid = req_valid & ~pulse;
            #1;
            n_cmp++;
            if (c == 1) begin
                if (eng_load !== 1'b1 || eng_step !== 1'b0 || eng_theta !== exp_theta ||
                    req_ready !== '0 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL load_cycle: load=%b step=%b theta=%h(exp %h) rdy=%b busy=%b rv=%b",
                             eng_load, eng_step, eng_theta, exp_theta, req_ready, busy, rsp_valid);
                end
            end else begin
                if (eng_step !== 1'b1 || eng_load !== 1'b0 || eng_iter !== IW'(c - 2) ||
                    req_ready !== '0 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL step_cycle %0d: step=%b load=%b iter=%0d(exp %0d) rdy=%b rv=%b",
                             c, eng_step, eng_load, eng_iter, c - 2, req_ready, rsp_valid);
                end
            end
        end
        @(negedge clk);
        for (int h = 0; h <= hold; h++) begin
            #1;
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_id !== IDW'(exp_id) || rsp_sin !== exp_theta ||
                rsp_cos !== W'(ITER) || eng_step !== 1'b0 || eng_load !== 1'b0 ||
                req_ready !== '0 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL resp_hold %0d: rv=%b id=%0d(exp %0d) sin=%h(exp %h) cos=%h(exp %h) step=%b rdy=%b",
                         h, rsp_valid, rsp_id, exp_id, rsp_sin, exp_theta, rsp_cos, W'(ITER), eng_step, req_ready);
            end
            if (h == hold) rsp_ready = 1'b1;
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL after_resp: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
        end
        m_rr = model_next_rr(exp_id, m_rr);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_rr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        req_valid_b = '1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({req_ready, eng_load, eng_step, eng_iter, eng_theta, rsp_valid, rsp_id, rsp_sin, rsp_cos, busy} !== '0 ||
            {req_ready_b, eng_load_b, eng_step_b, eng_iter_b, eng_theta_b, rsp_valid_b, rsp_id_b, rsp_sin_b, rsp_cos_b, busy_b} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: rdy=%b load=%b step=%b iter=%0d rv=%b busy=%b rdy_b=%b busy_b=%b expected all 0",
                     req_ready, eng_load, eng_step, eng_iter, rsp_valid, busy, req_ready_b, busy_b);
        end
        rst = 1'b0;
        req_valid = '0;
        req_valid_b = '0;
        m_rr = 0;
        #1;
        n_cmp++;
        if (req_ready !== '0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_no_request: req_ready=%b busy=%b expected 0 0", req_ready, busy);
        end
    endtask

    task automatic test_small_build();
        logic [W-1:0] th;
        th = W'($urandom);
        req_theta_b = {th, W'($urandom)};
        req_valid_b = 2'b10;
        #1;
        n_cmp++;
        if (req_ready_b !== 2'b10) begin
            n_bad++;
            $display("FAIL small_grant: req_ready=%b expected 10", req_ready_b);
        end
        for (int c = 1; c <= ITER2 + 1; c++) begin
            @(negedge clk);
            if (c == 1) req_valid_b = '0;
            #1;
            n_cmp++;
            if ((c == 1 && (eng_load_b !== 1'b1 || eng_theta_b !== th)) ||
                (c > 1 && (eng_step_b !== 1'b1 || eng_iter_b !== IW2'(c - 2)))) begin
                n_bad++;
                $display("FAIL small_cycle %0d: load=%b step=%b iter=%0d(exp %0d)", c, eng_load_b, eng_step_b, eng_iter_b, c - 2);
            end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (rsp_valid_b !== 1'b1 || eng_step_b !== 1'b0 || rsp_cos_b !== 16'h0008 ||
            rsp_sin_b !== th || rsp_id_b !== 1'b1) begin
            n_bad++;
            $display("FAIL small_resp: rv=%b step=%b cos=%h(exp 0008) sin=%h(exp %h) id=%0d(exp 1)",
                     rsp_valid_b, eng_step_b, rsp_cos_b, rsp_sin_b, th, rsp_id_b);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        int id;
        theta_arr[2] = 16'h1234;
        req_valid = 4'b0100;
        do_job(0, 4'b0010, 1'b1, 0, id);
        n_cmp++;
        if (id !== 2) begin
            n_bad++;
            $display("FAIL single_id: granted %0d expected 2", id);
        end
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (req_ready !== '0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL dropped_request: req_ready=%b busy=%b expected 0 0", req_ready, busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin();
        int id;
        int exp_order [5];
`ifdef CORDIC_SCHED_PRIO0_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        pulse_reset();
        for (int k = 0; k < NREQ; k++) theta_arr[k] = W'($urandom);
        req_valid = '1;
        for (int j = 0; j < 5; j++) begin
            do_job(0, '0, 1'b0, (j == 0) ? 0 : ITER + 3, id);
            n_cmp++;
            if (id !== exp_order[j]) begin
                n_bad++;
                $display("FAIL rr_order job %0d: granted %0d expected %0d", j, id, exp_order[j]);
            end
        end
    endtask

    task automatic test_backpressure();
        int id;
        req_valid = '1;
        do_job(10, '0, 1'b0, 0, id);
        do_job(0, '0, 1'b0, ITER + 3 + 10, id);
    endtask

    task automatic test_random();
        int id;
        for (int j = 0; j < 12; j++) begin
            for (int k = 0; k < NREQ; k++) theta_arr[k] = W'($urandom);
            req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            do_job($urandom_range(0, 3), '0, 1'b0, 0, id);
        end
    endtask

    task automatic test_reset_mid();
        int id;
        req_valid = 4'b0010;
        do_job(0, '0, 1'b0, 0, id);
        req_valid = 4'b0100;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL abort_grant: req_ready=%b expected 0100", req_ready);
        end
        for (int c = 1; c <= 9; c++) @(negedge clk);
        #1;
        n_cmp++;
        if (eng_step !== 1'b1 || eng_iter !== IW'(7)) begin
            n_bad++;
            $display("FAIL abort_at_step7: step=%b iter=%0d expected 1 7", eng_step, eng_iter);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({req_ready, eng_load, eng_step, eng_iter, eng_theta, rsp_valid, rsp_id, rsp_sin, rsp_cos, busy} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: step=%b iter=%0d rv=%b busy=%b rdy=%b expected all 0",
                     eng_step, eng_iter, rsp_valid, busy, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        m_rr = 0;
        for (int c = 0; c < ITER + 4; c++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (rsp_valid !== 1'b0 || eng_step !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL abandoned_job cycle %0d: rv=%b step=%b busy=%b expected 0 0 0", c, rsp_valid, eng_step, busy);
            end
        end
        req_valid = 4'b1010;
        do_job(0, '0, 1'b0, 0, id);
        n_cmp++;
        if (id !== 1) begin
            n_bad++;
            $display("FAIL rr_after_reset: granted %0d expected 1", id);
        end
        req_valid = '0;
    endtask

    task automatic test_prio0();
        int id;
        int exp_order [4];
`ifdef CORDIC_SCHED_PRIO0_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 3, 0, 3};
`endif
        pulse_reset();
        req_valid = 4'b1001;
        for (int j = 0; j < 4; j++) begin
            do_job(0, '0, 1'b0, 0, id);
            n_cmp++;
            if (id !== exp_order[j]) begin
                n_bad++;
                $display("FAIL prio_order job %0d: granted %0d expected %0d", j, id, exp_order[j]);
            end
        end
        req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NREQ; k++) theta_arr[k] = '0;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        test_small_build();
        test_single();
        test_round_robin();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_prio0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cordic_sched.md
Name: cordic_sched

Overview:
- Round-robin scheduler that shares one iterative sin/cos CORDIC engine among NREQ angle requesters.
- Per job it accepts an angle from one requester, loads the engine, and issues exactly ITER micro-rotation steps with the iteration index.
- It then returns the engine's y/x result as sine/cosine, tagged with the requester ID, on a valid/ready response port.
- Sits between the client blocks and the single shared CORDIC datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 16, angle/result width. Two's-complement fixed point, 2^14 = 1.0 rad.
- ITER, 16, engine iterations per job (1..16).
- IW, 4, width of the iteration index = ceil(log2(ITER)), minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_theta  in  NREQ*W  angles; requester k uses bits [k*W +: W]
- req_ready  out  NREQ  one-hot grant/accept
- eng_load  out  1  engine load strobe: x := gain constant, y := 0, z := eng_theta
- eng_theta  out  W  angle presented with eng_load
- eng_step  out  1  engine performs one micro-rotation this cycle
- eng_iter  out  IW  iteration index for the current step (shift amount / atan table index)
- eng_x  in  W  engine x register (cosine after ITER steps)
- eng_y  in  W  engine y register (sine after ITER steps)
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ceil(log2(NREQ))  requester index of the result
- rsp_sin  out  W  sine result
- rsp_cos  out  W  cosine result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0, iter_cnt=0. All outputs 0: eng_load, eng_step, eng_iter, eng_theta, rsp_*, busy. req_ready is forced 0 while rst is high.
- FSM states: IDLE -> LOAD -> ITER -> RESP -> IDLE.
- IDLE:
  - Grant g = first k with req_valid[k]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready = one-hot(g), driven combinationally, in IDLE only; all zero when no request is valid.
  - A transfer is req_valid[g] & req_ready[g]. On transfer, latch theta_q = req_theta[g] and id_q = g, then go to LOAD.
  - req_ready is 0 in every other state.
- LOAD (1 cycle): eng_load=1, eng_theta=theta_q, iter_cnt := 0, go to ITER.
- ITER (ITER cycles): eng_step=1, eng_iter=iter_cnt, iter_cnt increments.
  - When iter_cnt==ITER-1 on a step cycle, go to RESP.
  - eng_load and eng_step are never high together.
- RESP entry: register rsp_sin := eng_y and rsp_cos := eng_x, sampled the cycle after the last step. Set rsp_valid=1, rsp_id=id_q.
- RESP hold: rsp_valid and data stay stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid := 0, rr_ptr := (id_q+1) mod NREQ, go to IDLE.
- Latency: with the accept at cycle 0, LOAD is cycle 1, steps are cycles 2..ITER+1, and rsp_valid rises at cycle ITER+2 (18 for ITER=16).
- Throughput: with rsp_ready held high, one job per ITER+3 cycles. The next accept happens in the IDLE cycle after the response handshake.
- Boundary conditions:
  - req_valid dropping before grant: no effect.
  - A requester must hold req_theta stable while valid; the value is sampled only on transfer.
  - Requests arriving outside IDLE wait; nothing is lost or queued internally.
  - rr_ptr wraps NREQ-1 -> 0.
  - A single requester continuously valid is granted every job.
  - Reset mid-ITER or mid-RESP: the job is abandoned, no response is produced, eng_step drops immediately, and the engine is reloaded by the next job's LOAD.
  - Engine output values are passed through unmodified; no saturation.

Optional Feature:
- Macro: CORDIC_SCHED_PRIO0_EN.
- Defined: requester 0 has fixed top priority. If req_valid[0]=1 in IDLE, g=0 regardless of rr_ptr. Other requesters keep round-robin among themselves, and rr_ptr is not updated after requester-0 jobs.
- Undefined: pure round-robin as specified above.

Test Plan:
- The bench engine stub loads y := eng_theta and x := 0 on eng_load, and does x := x+1 per eng_step. Single request k=2 with theta=0x1234 -> req_ready=4'b0100 for one cycle; eng_load at +1 with eng_theta=0x1234; eng_iter 0..15 on cycles +2..+17; rsp_valid at +18 with rsp_sin=0x1234, rsp_cos=0x0010, rsp_id=2.
- All 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; one response every 19 cycles.
- rsp_ready=0 for 10 cycles in RESP -> rsp_valid and data hold; req_ready stays 0; no eng_step; accept occurs on the cycle after rsp_ready=1.
- rst pulsed at step 7 -> all outputs 0 asynchronously; no response; the next request restarts at eng_iter=0 and rr_ptr=0.
- ITER=8, NREQ=2 build -> exactly 8 step cycles, eng_iter 0..7, rsp_cos=0x0008.
- With CORDIC_SCHED_PRIO0_EN, requesters 0 and 3 continuously valid -> requester 0 wins every job; without the macro -> order alternates 0,3,0,3.
